// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cmp_pkg
// Brief   : Shared types and constants for the bit-serial magnitude comparator.
// Revision: 1.0 - initial release
// ============================================================================
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result encoding is {eq, lt, gt}; all-zero means no result available.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_magnitude_comparator_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_magnitude_comparator_if
// Brief   : Operand/handshake/result bundle for the sequential comparator.
// Revision: 1.0 - initial release
// ============================================================================
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, lt, gt
  );
endinterface
`default_nettype wire

// File: rtl/cmp_bit_decide.sv
`default_nettype none
// ============================================================================
// Module  : cmp_bit_decide
// Brief   : Single-bit compare step; decides which operand wins at a bit.
// Revision: 1.0 - initial release
// ============================================================================
module cmp_bit_decide (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_sign_bit,
  input  logic signed_mode,
  output logic differ,
  output logic a_greater
);

  assign differ = a_bit ^ b_bit;

  // At a signed sign bit the operand holding 0 is the larger one.
  assign a_greater = (is_sign_bit & signed_mode) ? b_bit : a_bit;

endmodule
`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module  : seq_magnitude_comparator
// Brief   : MSB-first bit-serial unsigned/signed comparator with early exit.
// Revision: 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  seq_magnitude_comparator_if.slave      bus
);
  import cmp_pkg::*;

  localparam int              CNT_W     = clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_msb_idx = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_smode;
  logic               r_busy;
  logic               r_done;
  logic [2:0]         r_res;

  logic               w_is_sign;
  logic               w_differ;
  logic               w_a_greater;

  assign w_is_sign = (r_cnt == c_msb_idx);

  cmp_bit_decide u_decide (
    .a_bit       (r_sa[WIDTH-1]),
    .b_bit       (r_sb[WIDTH-1]),
    .is_sign_bit (w_is_sign),
    .signed_mode (r_smode),
    .differ      (w_differ),
    .a_greater   (w_a_greater)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_smode <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= RES_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // DONE accepts a start exactly like IDLE for back-to-back operation.
        IDLE, DONE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_smode <= bus.signed_mode;
            r_cnt   <= c_msb_idx;
            r_res   <= RES_NONE;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (w_differ) begin
            r_res   <= w_a_greater ? RES_GT : RES_LT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == '0) begin
            r_res   <= RES_EQ;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
            r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.eq   = r_res[2];
  assign bus.lt   = r_res[1];
  assign bus.gt   = r_res[0];

endmodule
`default_nettype wire

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands. Operands are interpreted as unsigned or two's-complement signed, selected per operation. The block scans MSB-first, one bit per clock, and terminates early at the first differing bit. It reports one-hot eq/lt/gt with a start/busy/done handshake, and is a drop-in sequential replacement for combinational E/L/G comparators in lab datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32 (signed mode needs a sign bit plus at least one magnitude bit).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a comparison; sampled only while not busy.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
a  input  WIDTH  operand A; captured with an accepted start.
b  input  WIDTH  operand B; captured with an accepted start.
busy  output  1  high while scanning (SCAN state).
done  output  1  single-cycle pulse; result is valid from this cycle on.
eq  output  1  A == B.
lt  output  1  A < B.
gt  output  1  A > B.

Behaviour:
- Reset: while rst_n is low, state=IDLE and busy=done=eq=lt=gt=0, including mid-scan. eq/lt/gt all zero means "no result".
- FSM states: IDLE, SCAN, DONE.
- IDLE: start=1 is an accepted start.
  - Capture a, b and signed_mode into shift registers.
  - Load the bit counter with WIDTH-1.
  - Clear eq/lt/gt to 0 and go to SCAN.
- SCAN: busy=1. Each cycle compares the current MSB of both shift registers (bit index i = counter value).
  - Bits differ, i = WIDTH-1 and signed_mode=1: a=1 gives lt=1, otherwise gt=1 (sign bits decide inversely). Go to DONE.
  - Bits differ otherwise: a=1 gives gt=1, a=0 gives lt=1. Go to DONE.
  - Bits equal and i=0: eq=1, go to DONE.
  - Bits equal and i>0: shift both registers left by 1, decrement the counter, stay in SCAN.
- DONE: done=1 for exactly this cycle, busy=0.
  - start=1 here is accepted: same actions as IDLE, then go to SCAN (back-to-back operation).
  - Otherwise go to IDLE.
- Result hold: eq/lt/gt are registered. They are updated on the edge entering DONE and held until the next accepted start clears them. Exactly one of them is high whenever a result is valid.
- Latency: start accepted at edge T; bit i is examined in cycle T+(WIDTH-1-i)+1; done is high in the cycle after the deciding bit.
  - Minimum: 2 cycles (MSB differs).
  - Maximum: WIDTH+1 cycles (equal, or difference only at bit 0).
- start while busy is ignored, with no queuing.
- a, b and signed_mode changes after capture have no effect on the operation in flight.
- Width rules:
  - The counter is $clog2(WIDTH) bits.
  - Shift registers are WIDTH bits.
  - No arithmetic subtraction; the decision is purely bitwise.

Decomposition:
- Package cmp_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - result constants RES_NONE/RES_EQ/RES_LT/RES_GT as a 3-bit {eq,lt,gt} encoding;
  - the function clog2 for counter sizing.
- One combinational sub-module, cmp_bit_decide.
  - Inputs: a_bit, b_bit, is_sign_bit, signed_mode.
  - Outputs: differ, a_greater.
  - Instantiated once; the top holds the FSM, counter and shift registers.

Test Plan:
1. WIDTH=8, unsigned, a=0xA5, b=0xA5, start at T → busy high in T+1..T+8, done in T+9, eq=1, lt=gt=0, held until next start.
2. WIDTH=8, a=0x80, b=0x7F: signed → lt=1 with done in T+2; unsigned → gt=1 with done in T+2 (early termination at the sign bit).
3. WIDTH=8, signed, a=0xFE (-2), b=0xFF (-1) → lt=1, decided at bit 0, done in T+9. Then a=0x03, b=0xFD (-3) → gt=1, done in T+2.
4. Handshake:
   - Hold start=1 continuously while toggling a/b mid-scan → the in-flight result is unaffected and extra starts during busy are ignored.
   - start=1 in the DONE cycle → a new SCAN starts at the next edge, and eq/lt/gt clear to 0 at that edge.
5. Drop rst_n low mid-SCAN (asynchronously, between edges) → busy/done/eq/lt/gt go to 0 immediately without waiting for clk. After release, a fresh start with a=0x10, b=0x20 unsigned → lt=1 in T+4.
6. WIDTH=3, exhaustive: all 64 (a,b) pairs in both modes against a $signed/$unsigned golden model → one-hot correct result, done latency matches the formula, no X on outputs.
